fir_sequencer: RTL and testbench
================================

# fir_sequencer

Control FSM for the 4-tap FIR datapath: sequences the shared register file / ALU to load four coefficients and, per incoming sample, shift the sample history and run a 4-step multiply-accumulate. It sits between the input synchronizers (`dr`, `lc`) and the datapath, and drives the `modwait` handshake back to the host. It also drives the sample-counter controls behind `one_k_samples`, and raises `err` on arithmetic overflow or a lost sample.

## Interface
Parameters:
- `NUM_REGS`, 16: datapath register-file depth; register index width is `$clog2(NUM_REGS)` (4).
- `OP_W`, 3: opcode width.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dr`  in  1  synchronized data_ready.
- `lc`  in  1  synchronized load_coeff.
- `overflow`  in  1  datapath ALU overflow flag, combinational from current op.
- `cnt_up`  out  1  one-cycle pulse, increments sample counter.
- `clear`  out  1  one-cycle pulse, clears sample counter.
- `modwait`  out  1  busy/handshake to host.
- `op`  out  3  ALU opcode: NOP=0, COPY=1, LOAD1(sample)=2, LOAD2(coeff)=3, ADD=4, SUB=5, MUL=6.
- `src1`, `src2`, `dest`  out  4 each  register indices.
- `err`  out  1  error flag.

## Operation
- Register map: R0 accumulator/fir_out, R1..R4 sample history (R4 newest), R5 incoming sample, R6 product, R7..R10 coefficients F0..F3.
- Moore FSM. All outputs are decoded from the state register only. Each state lasts one cycle unless noted.
- Reset: state=IDLE; op=NOP, src/dest=0, `cnt_up`=`clear`=`modwait`=`err`=0.
- IDLE:
  - `dr`=1 → STORE.
  - else `lc`=1 → LOADC0.
  - `dr` wins if both are high.
- Sample path:
  - STORE (LOAD1, dest R5, `cnt_up`=1). If `dr`=0 here → EIDLE (sample lost).
  - ZERO (SUB R0,R0→R0).
  - SORT1 R2→R1, SORT2 R3→R2, SORT3 R4→R3, SORT4 R5→R4 (all COPY).
  - MUL1 R1×R7→R6, ADD1 R0+R6→R0.
  - MUL2 R2×R8→R6, SUB2 R0−R6→R0.
  - MUL3 R3×R9→R6, ADD3 R0+R6→R0.
  - MUL4 R4×R10→R6, SUB4 R0−R6→R0 → IDLE.
- Coefficient path:
  - LOADC0 (LOAD2 dest R7, `clear`=1) → WAITC0.
  - WAITCn (NOP): wait until `lc`=1 → LOADC(n+1).
  - LOADC1 dest R8, LOADC2 dest R9, LOADC3 dest R10 → IDLE.
  - `dr` is ignored from LOADC0 through LOADC3.
- EIDLE: `err`=1, op=NOP. `dr`=1 → STORE (err clears that cycle); `lc` ignored.
- `modwait`=1 in every state except IDLE, EIDLE, WAITC0..2.
- Arithmetic (saturation, fixed-point scaling) is owned by the datapath. The sequencer only issues ops.

## Timing
- `dr` sampled high in IDLE at edge k → STORE in cycle k+1. `modwait` rises in the same cycle (one-cycle latency).
- Sample path is 14 busy cycles (STORE..SUB4). `modwait` falls in cycle k+15 and R0 is final at that edge.
- Each LOADCn is one busy cycle. `modwait` pulses high 1 cycle per coefficient.
- `overflow` is sampled at the edge leaving ADD1/SUB2/ADD3/SUB4; if high → EIDLE instead of the next state. MUL overflow is ignored.
- `reset` mid-sequence: IDLE next edge regardless of state; partially loaded coefficients stay in the datapath, and `err` drops.
- `dr` held high after completion re-triggers STORE from IDLE. The host must drop `dr` after `modwait` rises.

## Configuration
- `FIR_SEQ_OVF_CHECK_EN` defined: overflow check in ADD/SUB states as above.
- Not defined: `overflow` input unused and ADD1..SUB4 always advance. EIDLE is reachable only via a lost sample in STORE.

## Test plan
- Reset, then `lc` four times, one pulse each, ≥3 cycles apart → `clear` pulses once; dest sequence R7,R8,R9,R10 with op=3; `modwait` high 1 cycle per LOADCn; final state IDLE.
- `dr` held 2 cycles in IDLE → `cnt_up` 1 pulse; `modwait` high exactly 14 cycles; op sequence 2,5,1,1,1,1,6,4,6,5,6,4,6,5.
- `overflow`=1 during SUB2 (macro defined) → EIDLE next cycle, `err`=1, `modwait`=0; next `dr` → STORE with `err`=0.
- Same stimulus with macro undefined → sequence completes to IDLE, `err` stays 0.
- `dr` pulsed 1 cycle (low in STORE) → EIDLE, `err`=1, `cnt_up` still pulsed once.
- `reset`=1 during MUL3 → all outputs 0 next cycle, state IDLE; `dr` and `lc` high together in IDLE → STORE.

Source files
------------

// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_sequencer
// Brief    : Moore control FSM for the 4-tap FIR datapath. Loads four
//            coefficients on load_coeff requests and, for every incoming
//            sample, shifts the sample history and runs a 4-step
//            multiply-accumulate (taps alternate +, -, +, -).
// Options  : FIR_SEQ_OVF_CHECK_EN - when defined, an ALU overflow seen in
//            an ADD/SUB step of the MAC aborts to the error state.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dr,
    input  logic                        lc,
    input  logic                        overflow,
    output logic                        cnt_up,
    output logic                        clear,
    output logic                        modwait,
    output logic [OP_W-1:0]             op,
    output logic [$clog2(NUM_REGS)-1:0] src1,
    output logic [$clog2(NUM_REGS)-1:0] src2,
    output logic [$clog2(NUM_REGS)-1:0] dest,
    output logic                        err
);

    localparam int c_REG_W = $clog2(NUM_REGS);

    // ALU opcodes
    localparam logic [OP_W-1:0] c_OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_COPY  = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_LOAD1 = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_LOAD2 = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_ADD   = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_SUB   = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_MUL   = OP_W'(6);

    // Register map: R0 accumulator, R1..R4 history (R4 newest),
    // R5 incoming sample, R6 product, R7..R10 coefficients F0..F3.
    localparam logic [c_REG_W-1:0] c_R0  = c_REG_W'(0);
    localparam logic [c_REG_W-1:0] c_R1  = c_REG_W'(1);
    localparam logic [c_REG_W-1:0] c_R2  = c_REG_W'(2);
    localparam logic [c_REG_W-1:0] c_R3  = c_REG_W'(3);
    localparam logic [c_REG_W-1:0] c_R4  = c_REG_W'(4);
    localparam logic [c_REG_W-1:0] c_R5  = c_REG_W'(5);
    localparam logic [c_REG_W-1:0] c_R6  = c_REG_W'(6);
    localparam logic [c_REG_W-1:0] c_R7  = c_REG_W'(7);
    localparam logic [c_REG_W-1:0] c_R8  = c_REG_W'(8);
    localparam logic [c_REG_W-1:0] c_R9  = c_REG_W'(9);
    localparam logic [c_REG_W-1:0] c_R10 = c_REG_W'(10);

    // State encoding
    localparam logic [4:0] c_S_IDLE   = 5'd0;
    localparam logic [4:0] c_S_STORE  = 5'd1;
    localparam logic [4:0] c_S_ZERO   = 5'd2;
    localparam logic [4:0] c_S_SORT1  = 5'd3;
    localparam logic [4:0] c_S_SORT2  = 5'd4;
    localparam logic [4:0] c_S_SORT3  = 5'd5;
    localparam logic [4:0] c_S_SORT4  = 5'd6;
    localparam logic [4:0] c_S_MUL1   = 5'd7;
    localparam logic [4:0] c_S_ADD1   = 5'd8;
    localparam logic [4:0] c_S_MUL2   = 5'd9;
    localparam logic [4:0] c_S_SUB2   = 5'd10;
    localparam logic [4:0] c_S_MUL3   = 5'd11;
    localparam logic [4:0] c_S_ADD3   = 5'd12;
    localparam logic [4:0] c_S_MUL4   = 5'd13;
    localparam logic [4:0] c_S_SUB4   = 5'd14;
    localparam logic [4:0] c_S_LOADC0 = 5'd15;
    localparam logic [4:0] c_S_WAITC0 = 5'd16;
    localparam logic [4:0] c_S_LOADC1 = 5'd17;
    localparam logic [4:0] c_S_WAITC1 = 5'd18;
    localparam logic [4:0] c_S_LOADC2 = 5'd19;
    localparam logic [4:0] c_S_WAITC2 = 5'd20;
    localparam logic [4:0] c_S_LOADC3 = 5'd21;
    localparam logic [4:0] c_S_EIDLE  = 5'd22;

    logic [4:0] r_state;
    logic [4:0] w_next_state;
    logic       w_ovf_abort;

`ifdef FIR_SEQ_OVF_CHECK_EN
    // An overflowing accumulate step aborts the sample.
    assign w_ovf_abort = overflow;
`else
    // Overflow is left entirely to the datapath; the MAC always completes.
    logic w_unused_overflow;
    assign w_unused_overflow = overflow;
    assign w_ovf_abort       = 1'b0;
`endif

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: dr has priority over lc in IDLE; dr is ignored
    // throughout the coefficient path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (dr) begin
                    w_next_state = c_S_STORE;
                end else if (lc) begin
                    w_next_state = c_S_LOADC0;
                end
            end
            // dr must still be high while the sample is captured,
            // otherwise the sample is considered lost.
            c_S_STORE:  w_next_state = dr ? c_S_ZERO : c_S_EIDLE;
            c_S_ZERO:   w_next_state = c_S_SORT1;
            c_S_SORT1:  w_next_state = c_S_SORT2;
            c_S_SORT2:  w_next_state = c_S_SORT3;
            c_S_SORT3:  w_next_state = c_S_SORT4;
            c_S_SORT4:  w_next_state = c_S_MUL1;
            c_S_MUL1:   w_next_state = c_S_ADD1;
            c_S_ADD1:   w_next_state = w_ovf_abort ? c_S_EIDLE : c_S_MUL2;
            c_S_MUL2:   w_next_state = c_S_SUB2;
            c_S_SUB2:   w_next_state = w_ovf_abort ? c_S_EIDLE : c_S_MUL3;
            c_S_MUL3:   w_next_state = c_S_ADD3;
            c_S_ADD3:   w_next_state = w_ovf_abort ? c_S_EIDLE : c_S_MUL4;
            c_S_MUL4:   w_next_state = c_S_SUB4;
            c_S_SUB4:   w_next_state = w_ovf_abort ? c_S_EIDLE : c_S_IDLE;
            c_S_LOADC0: w_next_state = c_S_WAITC0;
            c_S_WAITC0: w_next_state = lc ? c_S_LOADC1 : c_S_WAITC0;
            c_S_LOADC1: w_next_state = c_S_WAITC1;
            c_S_WAITC1: w_next_state = lc ? c_S_LOADC2 : c_S_WAITC1;
            c_S_LOADC2: w_next_state = c_S_WAITC2;
            c_S_WAITC2: w_next_state = lc ? c_S_LOADC3 : c_S_WAITC2;
            c_S_LOADC3: w_next_state = c_S_IDLE;
            // Only a new sample leaves the error state; lc is ignored.
            c_S_EIDLE:  w_next_state = dr ? c_S_STORE : c_S_EIDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        op      = c_OP_NOP;
        src1    = c_R0;
        src2    = c_R0;
        dest    = c_R0;
        cnt_up  = 1'b0;
        clear   = 1'b0;
        modwait = 1'b0;
        err     = 1'b0;
        case (r_state)
            c_S_STORE: begin
                op      = c_OP_LOAD1;
                dest    = c_R5;
                cnt_up  = 1'b1;
                modwait = 1'b1;
            end
            c_S_ZERO: begin
                op      = c_OP_SUB;
                modwait = 1'b1;
            end
            c_S_SORT1: begin
                op      = c_OP_COPY;
                src1    = c_R2;
                dest    = c_R1;
                modwait = 1'b1;
            end
            c_S_SORT2: begin
                op      = c_OP_COPY;
                src1    = c_R3;
                dest    = c_R2;
                modwait = 1'b1;
            end
            c_S_SORT3: begin
                op      = c_OP_COPY;
                src1    = c_R4;
                dest    = c_R3;
                modwait = 1'b1;
            end
            c_S_SORT4: begin
                op      = c_OP_COPY;
                src1    = c_R5;
                dest    = c_R4;
                modwait = 1'b1;
            end
            c_S_MUL1: begin
                op      = c_OP_MUL;
                src1    = c_R1;
                src2    = c_R7;
                dest    = c_R6;
                modwait = 1'b1;
            end
            c_S_MUL2: begin
                op      = c_OP_MUL;
                src1    = c_R2;
                src2    = c_R8;
                dest    = c_R6;
                modwait = 1'b1;
            end
            c_S_MUL3: begin
                op      = c_OP_MUL;
                src1    = c_R3;
                src2    = c_R9;
                dest    = c_R6;
                modwait = 1'b1;
            end
            c_S_MUL4: begin
                op      = c_OP_MUL;
                src1    = c_R4;
                src2    = c_R10;
                dest    = c_R6;
                modwait = 1'b1;
            end
            c_S_ADD1, c_S_ADD3: begin
                op      = c_OP_ADD;
                src2    = c_R6;
                modwait = 1'b1;
            end
            c_S_SUB2, c_S_SUB4: begin
                op      = c_OP_SUB;
                src2    = c_R6;
                modwait = 1'b1;
            end
            c_S_LOADC0: begin
                op      = c_OP_LOAD2;
                dest    = c_R7;
                clear   = 1'b1;
                modwait = 1'b1;
            end
            c_S_LOADC1: begin
                op      = c_OP_LOAD2;
                dest    = c_R8;
                modwait = 1'b1;
            end
            c_S_LOADC2: begin
                op      = c_OP_LOAD2;
                dest    = c_R9;
                modwait = 1'b1;
            end
            c_S_LOADC3: begin
                op      = c_OP_LOAD2;
                dest    = c_R10;
                modwait = 1'b1;
            end
            c_S_EIDLE: begin
                err = 1'b1;
            end
            default: begin
                op = c_OP_NOP;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sequencer
// Brief    : Directed self-checking bench for fir_sequencer: coefficient
//            load, full sample MAC sequence, overflow abort (build
//            dependent on FIR_SEQ_OVF_CHECK_EN), lost sample, mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;

    logic       tb_clk;
    logic       reset;
    logic       dr;
    logic       lc;
    logic       overflow;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       err;

    int n_compared;
    int n_mismatched;

    // Expected per-cycle decode of the 14-cycle sample path (STORE..SUB4).
    int exp_op   [14] = '{2, 5, 1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
    int exp_src1 [14] = '{0, 0, 2, 3, 4, 5, 1, 0, 2, 0, 3, 0, 4, 0};
    int exp_src2 [14] = '{0, 0, 0, 0, 0, 0, 7, 6, 8, 6, 9, 6, 10, 6};
    int exp_dest [14] = '{5, 0, 1, 2, 3, 4, 6, 0, 6, 0, 6, 0, 6, 0};

    fir_sequencer #(
        .NUM_REGS (16),
        .OP_W     (3)
    ) dut (
        .clk      (tb_clk),
        .reset    (reset),
        .dr       (dr),
        .lc       (lc),
        .overflow (overflow),
        .cnt_up   (cnt_up),
        .clear    (clear),
        .modwait  (modwait),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .err      (err)
    );

    // Free-running clock, 10 time-unit period.
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op"},      32'(op),      0);
        check({tag, "_src1"},    32'(src1),    0);
        check({tag, "_src2"},    32'(src2),    0);
        check({tag, "_dest"},    32'(dest),    0);
        check({tag, "_cnt_up"},  32'(cnt_up),  0);
        check({tag, "_clear"},   32'(clear),   0);
        check({tag, "_modwait"}, 32'(modwait), 0);
        check({tag, "_err"},     32'(err),     0);
    endtask

    initial begin
        int clr_cnt;
        int mw_cnt;
        int cu_cnt;

        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        dr       = 1'b0;
        lc       = 1'b0;
        overflow = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        step();
        check_all_zero("rst");
        reset = 1'b0;
        step();
        check_all_zero("post_rst");

        // ---------------- coefficient load ----------------
        clr_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            lc = 1'b1;
            step();
            lc = 1'b0;
            check("ldc_op",      32'(op),      3);
            check("ldc_dest",    32'(dest),    32'(7 + n));
            check("ldc_modwait", 32'(modwait), 1);
            clr_cnt += int'(clear);
            for (int g = 0; g < 3; g++) begin
                // dr pulsed while waiting for the second coefficient: ignored
                dr = (n == 0 && g < 2);
                step();
                check("ldc_gap_modwait", 32'(modwait), 0);
                check("ldc_gap_op",      32'(op),      0);
                clr_cnt += int'(clear);
            end
            dr = 1'b0;
        end
        check("ldc_clear_pulses", 32'(clr_cnt), 1);

        // ---------------- full sample path ----------------
        dr     = 1'b1;
        mw_cnt = 0;
        cu_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 1) dr = 1'b0;
            if (c == 0)  check("smp_mw_rise", 32'(modwait), 1);
            if (c == 14) check("smp_mw_fall", 32'(modwait), 0);
            if (modwait) begin
                if (mw_cnt < 14) begin
                    check("smp_op",   32'(op),   32'(exp_op[mw_cnt]));
                    check("smp_src1", 32'(src1), 32'(exp_src1[mw_cnt]));
                    check("smp_src2", 32'(src2), 32'(exp_src2[mw_cnt]));
                    check("smp_dest", 32'(dest), 32'(exp_dest[mw_cnt]));
                end
                mw_cnt++;
            end
            cu_cnt += int'(cnt_up);
        end
        check("smp_busy_cycles", 32'(mw_cnt), 14);
        check("smp_cnt_up",      32'(cu_cnt), 1);
        check("smp_err",         32'(err),    0);

        // ---------------- overflow during SUB2 ----------------
        dr = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 1) dr = 1'b0;
        end
        check("ovf_in_sub2_op",   32'(op),   5);
        check("ovf_in_sub2_src2", 32'(src2), 6);
        overflow = 1'b1;
        step();
        overflow = 1'b0;
`ifdef FIR_SEQ_OVF_CHECK_EN
        check("ovf_err",     32'(err),     1);
        check("ovf_modwait", 32'(modwait), 0);
        check("ovf_op",      32'(op),      0);
        step();
        check("ovf_err_hold", 32'(err), 1);
        lc = 1'b1;
        step();
        lc = 1'b0;
        check("ovf_lc_ignored_err", 32'(err),     1);
        check("ovf_lc_ignored_mw",  32'(modwait), 0);
        dr = 1'b1;
        step();
        check("ovf_restart_op",  32'(op),     2);
        check("ovf_restart_err", 32'(err),    0);
        check("ovf_restart_cu",  32'(cnt_up), 1);
        step();
        dr = 1'b0;
        for (int c = 0; c < 13; c++) step();
        check("ovf_done_mw",  32'(modwait), 0);
        check("ovf_done_err", 32'(err),     0);
`else
        check("noovf_op",      32'(op),      6);
        check("noovf_err",     32'(err),     0);
        check("noovf_modwait", 32'(modwait), 1);
        for (int c = 0; c < 4; c++) begin
            step();
            check("noovf_run_err", 32'(err), 0);
        end
        check("noovf_done_mw", 32'(modwait), 0);
        check("noovf_done_op", 32'(op),      0);
`endif

        // ---------------- lost sample ----------------
        dr = 1'b1;
        step();
        check("lost_store_cu", 32'(cnt_up), 1);
        dr = 1'b0;
        step();
        check("lost_err",     32'(err),     1);
        check("lost_modwait", 32'(modwait), 0);
        check("lost_cu",      32'(cnt_up),  0);
        lc = 1'b1;
        step();
        lc = 1'b0;
        check("lost_lc_err",   32'(err),   1);
        check("lost_lc_clear", 32'(clear), 0);
        check("lost_lc_op",    32'(op),    0);

        // ---------------- reset during MUL3 ----------------
        dr = 1'b1;
        step();
        check("rec_store_err", 32'(err), 0);
        check("rec_store_op",  32'(op),  2);
        step();
        dr = 1'b0;
        for (int c = 0; c < 9; c++) step();
        check("mul3_op",   32'(op),   6);
        check("mul3_src1", 32'(src1), 3);
        check("mul3_src2", 32'(src2), 9);
        reset = 1'b1;
        step();
        check_all_zero("midrst");
        reset = 1'b0;
        dr    = 1'b1;
        lc    = 1'b1;
        step();
        lc = 1'b0;
        check("prio_op",      32'(op),      2);
        check("prio_dest",    32'(dest),    5);
        check("prio_modwait", 32'(modwait), 1);
        check("prio_clear",   32'(clear),   0);
        step();
        dr = 1'b0;
        for (int c = 0; c < 13; c++) step();
        check("final_modwait", 32'(modwait), 0);
        check("final_err",     32'(err),     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
